// File: rtl/mem_stage.sv
// mem_stage: data-memory access stage between execute and writeback; one registered result pulse per instruction.
// Latency 1 for non-memory ops and faults, 2+ for bus ops; M_ready_o stays low while a bus access is outstanding.
module mem_stage #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk_i,
  input  logic            rst,
  input  logic            E_valid_i,
  input  logic [XLEN-1:0] E_valE_i,
  input  logic [XLEN-1:0] E_rs2_data_i,
  input  logic            E_load_i,
  input  logic            E_store_i,
  input  logic [2:0]      E_funct3_i,
  input  logic [4:0]      E_rd_i,
  input  logic            E_wen_i,
  output logic            M_ready_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [31:0]     dmem_wdata_o,
  output logic [3:0]      dmem_wstrb_o,
  input  logic            dmem_ack_i,
  input  logic [31:0]     dmem_rdata_i,
  output logic            M_valid_o,
  output logic [XLEN-1:0] M_valM_o,
  output logic [4:0]      M_rd_o,
  output logic            M_wen_o,
  output logic            M_exc_o,
  output logic [1:0]      M_exc_cause_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [0:0]      state_q, state_d;
  logic            req_q, req_d, we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            valid_q, valid_d, wen_q, wen_d, exc_q, exc_d;
  logic [XLEN-1:0] valm_q, valm_d;
  logic [4:0]      rd_q, rd_d;
  logic [1:0]      cause_q, cause_d;
  // Latched copy of the accepted instruction, consumed when the bus access ends.
  logic [XLEN-1:0] p_vale_q, p_vale_d;
  logic [2:0]      p_f3_q, p_f3_d;
  logic            p_load_q, p_load_d, p_wen_q, p_wen_d;
  logic [4:0]      p_rd_q, p_rd_d;

  logic            is_mem, size_ok, misal;
  logic [31:0]     st_wdata;
  logic [3:0]      st_wstrb;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_val;

  assign is_mem  = E_load_i | E_store_i;
  assign size_ok = E_load_i ? (E_funct3_i != 3'b011 && E_funct3_i[2:1] != 2'b11)
                            : (E_funct3_i[2] == 1'b0 && E_funct3_i[1:0] != 2'b11);
  assign misal   = (E_funct3_i[1:0] == 2'b01 && E_valE_i[0]) ||
                   (E_funct3_i[1:0] == 2'b10 && E_valE_i[1:0] != 2'b00);
  assign ld_half = p_vale_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

  always_comb begin
    st_wdata = E_rs2_data_i[31:0];
    st_wstrb = 4'b1111;
    case (E_funct3_i[1:0])
      2'b00: begin
        st_wdata = {4{E_rs2_data_i[7:0]}};
        st_wstrb = 4'b0001 << E_valE_i[1:0];
      end
      2'b01: begin
        st_wdata = {2{E_rs2_data_i[15:0]}};
        st_wstrb = E_valE_i[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = dmem_rdata_i[7:0];
    case (p_vale_q[1:0])
      2'b01:   ld_byte = dmem_rdata_i[15:8];
      2'b10:   ld_byte = dmem_rdata_i[23:16];
      2'b11:   ld_byte = dmem_rdata_i[31:24];
      default: ;
    endcase
    case (p_f3_q)
      3'b000:  ld_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_val = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_val = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_val = XLEN'(dmem_rdata_i);
    endcase
  end

  always_comb begin
    state_d  = state_q;  req_d   = req_q;   we_d    = we_q;
    addr_d   = addr_q;   wdata_d = wdata_q; wstrb_d = wstrb_q;
    cnt_d    = cnt_q;    valid_d = 1'b0;    valm_d  = valm_q;
    rd_d     = rd_q;     wen_d   = wen_q;   exc_d   = exc_q;
    cause_d  = cause_q;
    p_vale_d = p_vale_q; p_f3_d  = p_f3_q;  p_load_d = p_load_q;
    p_wen_d  = p_wen_q;  p_rd_d  = p_rd_q;
    case (state_q)
      S_IDLE: begin
        if (E_valid_i) begin
          p_vale_d = E_valE_i;  p_f3_d = E_funct3_i; p_load_d = E_load_i;
          p_wen_d  = E_wen_i;   p_rd_d = E_rd_i;
          if (!is_mem || !size_ok || misal) begin
            valid_d = 1'b1;
            valm_d  = E_valE_i;
            rd_d    = E_rd_i;
            wen_d   = is_mem ? 1'b0 : E_wen_i;
            exc_d   = is_mem;
            cause_d = !is_mem ? 2'b00 : (!size_ok ? 2'b11 : 2'b01);
          end else begin
            state_d = S_BUSY;
            req_d   = 1'b1;
            we_d    = !E_load_i;
            addr_d  = {E_valE_i[XLEN-1:2], 2'b00};
            wdata_d = st_wdata;
            wstrb_d = E_load_i ? 4'b0000 : st_wstrb;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        // Ack beats timeout when both land on the same edge.
        if (dmem_ack_i || cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          valid_d = 1'b1;
          rd_d    = p_rd_q;
          exc_d   = !dmem_ack_i;
          cause_d = dmem_ack_i ? 2'b00 : 2'b10;
          wen_d   = dmem_ack_i && p_load_q && p_wen_q;
          valm_d  = (dmem_ack_i && p_load_q) ? ld_val : p_vale_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE; req_q   <= 1'b0; we_q    <= 1'b0;
      addr_q   <= '0;     wdata_q <= '0;   wstrb_q <= '0;
      cnt_q    <= '0;     valid_q <= 1'b0; valm_q  <= '0;
      rd_q     <= '0;     wen_q   <= 1'b0; exc_q   <= 1'b0;
      cause_q  <= '0;
      p_vale_q <= '0;     p_f3_q  <= '0;   p_load_q <= 1'b0;
      p_wen_q  <= 1'b0;   p_rd_q  <= '0;
    end else begin
      state_q  <= state_d;  req_q   <= req_d;   we_q    <= we_d;
      addr_q   <= addr_d;   wdata_q <= wdata_d; wstrb_q <= wstrb_d;
      cnt_q    <= cnt_d;    valid_q <= valid_d; valm_q  <= valm_d;
      rd_q     <= rd_d;     wen_q   <= wen_d;   exc_q   <= exc_d;
      cause_q  <= cause_d;
      p_vale_q <= p_vale_d; p_f3_q  <= p_f3_d;  p_load_q <= p_load_d;
      p_wen_q  <= p_wen_d;  p_rd_q  <= p_rd_d;
    end
  end

  assign M_ready_o     = (state_q == S_IDLE);
  assign dmem_req_o    = req_q;
  assign dmem_we_o     = we_q;
  assign dmem_addr_o   = addr_q;
  assign dmem_wdata_o  = wdata_q;
  assign dmem_wstrb_o  = wstrb_q;
  assign M_valid_o     = valid_q;
  assign M_valM_o      = valm_q;
  assign M_rd_o        = rd_q;
  assign M_wen_o       = wen_q;
  assign M_exc_o       = exc_q;
  assign M_exc_cause_o = cause_q;

endmodule
